booth_accumulator: RTL and testbench
====================================

BOOTH_ACCUMULATOR -- requirements
Module: booth_accumulator

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of products summed per result; legal range 1..15.
REQ-002 Parameter ACC_W, default 10: signed accumulator and result width; legal range 9..16.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port product, input, 8: two's-complement product from the upstream booth_multiplier.
REQ-006 Port done, input, 1: upstream completion flag, level-held high until the upstream block is reset.
REQ-007 Port clear, input, 1: synchronous flush of all state, active-high.
REQ-008 Port result_ready, input, 1: downstream accepts the result.
REQ-009 Port acc_result, output, ACC_W: signed frame sum.
REQ-010 Port result_valid, output, 1: acc_result holds a completed frame.
REQ-011 Port sat_flag, output, 1: sticky flag; the current frame saturated.
REQ-012 Port overrun, output, 1: sticky flag; a product was dropped because the FIFO was full.
REQ-013 Port prod_count, output, 4: products accumulated in the current frame.

Function
REQ-014 Capture: on each edge where done=1 and done_q=0, the block SHALL write product into a 2-entry FIFO; done_q is done registered one cycle earlier. A level-held done SHALL yield exactly one capture.
REQ-015 The FIFO SHALL allow a push and a pop in the same cycle. When full with no simultaneous pop, a capture SHALL be dropped and overrun SHALL be set.
REQ-016 FSM states SHALL be ACC and HOLD; reset state is ACC.
REQ-017 ACC: when the FIFO is non-empty, each edge SHALL pop one entry and add it to acc. The entry is sign-extended to ACC_W+1 bits.
REQ-018 Arithmetic: a sum above 2^(ACC_W-1)-1 SHALL clamp to that value. A sum below -2^(ACC_W-1) SHALL clamp to that value. Either clamp SHALL set sat_flag.
REQ-019 prod_count SHALL increment on each pop.
REQ-020 When a pop makes prod_count equal FRAME_LEN, the same edge SHALL move the FSM to HOLD. From the next cycle, result_valid=1 and acc_result equals the final sum.
REQ-021 Latency: capture edge N, pop/add edge N+1, result_valid high after edge N+1 for the last product of a frame.
REQ-022 HOLD: no pops SHALL occur; captures continue into the FIFO. acc_result, sat_flag and prod_count SHALL stay stable.
REQ-023 HOLD with result_ready=1: the edge SHALL return the FSM to ACC and clear acc, prod_count and sat_flag to 0. result_valid SHALL drop after that edge.
REQ-024 result_ready SHALL be ignored in ACC.
REQ-025 acc_result SHALL equal the running acc in ACC and the frozen sum in HOLD.
REQ-026 clear=1 SHALL have the same effect as reset on the next edge, including the FIFO, done_q and overrun. clear SHALL take priority over capture, pop and handshake.
REQ-027 Reset or clear mid-frame SHALL discard partial sums and all FIFO contents.
REQ-028 overrun SHALL be cleared only by reset or clear.

Reset
REQ-029 On reset assertion, immediately and independent of clk, the block SHALL set acc_result=0, result_valid=0, sat_flag=0, overrun=0, prod_count=0, FIFO empty, done_q=0, FSM=ACC.
REQ-030 The first edge after reset deassertion with done already high SHALL count as a rising edge, because done_q=0.

Verification
REQ-031 Eight done pulses with product 0x23, 0xF4, 0x04, 0xFF, 0x00, 0x07, 0x00, 0x00 and result_ready=0 -> result_valid=1, acc_result=10'd33, sat_flag=0, prod_count=8. Held until ready; result_ready=1 for one cycle -> result_valid=0, acc_result=0.
REQ-032 Eight products of 0x40 (64) -> acc_result=10'h1FF (511), sat_flag=1. Eight products of 0xC8 (-56) -> acc_result=-448, sat_flag=0.
REQ-033 done held high for 20 cycles with product 0x05 -> exactly one capture, prod_count=1, acc_result=5.
REQ-034 In HOLD, three captures before result_ready -> the first two are retained, overrun=1. After ready, the first two are accumulated within 2 cycles, prod_count=2.
REQ-035 Reset, or separately clear, asserted after 5 products -> all outputs 0, FIFO empty. A following 8-product frame sums from zero.

Source files
------------

// File: rtl/booth_accumulator.sv
// booth_accumulator: frames upstream booth products into saturating sums.
// Two-entry capture FIFO feeds an ACC/HOLD accumulator with a result handshake.
module booth_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              product,
  input  logic                    done,
  input  logic                    clear,
  input  logic                    result_ready,
  output logic signed [ACC_W-1:0] acc_result,
  output logic                    result_valid,
  output logic                    sat_flag,
  output logic                    overrun,
  output logic [3:0]              prod_count
);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  localparam logic [3:0] FRAME_CNT = 4'(FRAME_LEN);

  localparam logic signed [ACC_W-1:0] POS_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] NEG_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  state_t     state;
  logic       done_q;
  logic [7:0] fifo_mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] fifo_cnt;

  logic       capture;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  logic [7:0] head;

  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    sum_clip;
  logic [3:0]              next_cnt;

  // Edge-detect done and decide FIFO push/pop/drop for this cycle
  always_comb begin
    capture = done & ~done_q;
    full    = (fifo_cnt == 2'd2);
    pop     = (state == ACC) && (fifo_cnt != 2'd0);
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
    head    = fifo_mem[rd_ptr];
  end

  // Widen by one bit so the add cannot wrap, then clamp to the signed range
  always_comb begin
    sum_ext  = {acc_result[ACC_W-1], acc_result}
             + {{(ACC_W-7){head[7]}}, head};
    sum_clip = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    sum_sat  = sum_ext[ACC_W-1:0];
    if (sum_clip) begin
      sum_sat = sum_ext[ACC_W] ? NEG_MIN : POS_MAX;
    end
    next_cnt = prod_count + 4'd1;
  end

  // FIFO storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      fifo_mem[wr_ptr] <= product;
    end
  end

  // done history, FIFO pointers/occupancy and the sticky overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q   <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      overrun  <= 1'b0;
    end else if (clear) begin
      done_q   <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      overrun  <= 1'b0;
    end else begin
      done_q <= done;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // ACC/HOLD state machine with the accumulator and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACC;
      acc_result   <= '0;
      prod_count   <= 4'd0;
      sat_flag     <= 1'b0;
      result_valid <= 1'b0;
    end else if (clear) begin
      state        <= ACC;
      acc_result   <= '0;
      prod_count   <= 4'd0;
      sat_flag     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (pop) begin
            acc_result <= sum_sat;
            prod_count <= next_cnt;
            if (sum_clip) begin
              sat_flag <= 1'b1;
            end
            if (next_cnt == FRAME_CNT) begin
              state        <= HOLD;
              result_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            state        <= ACC;
            acc_result   <= '0;
            prod_count   <= 4'd0;
            sat_flag     <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_accumulator.sv
// tb_booth_accumulator: scenario tasks against a frame-sum reference model.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_booth_accumulator;

  localparam int FRAME_LEN = 8;
  localparam int ACC_W     = 10;
  localparam int SMAX      = (1 << (ACC_W - 1)) - 1;
  localparam int SMIN      = -(1 << (ACC_W - 1));

  logic                    clk;
  logic                    reset;
  logic [7:0]              product;
  logic                    done;
  logic                    clear;
  logic                    result_ready;
  logic signed [ACC_W-1:0] acc_result;
  logic                    result_valid;
  logic                    sat_flag;
  logic                    overrun;
  logic [3:0]              prod_count;

  int checks;
  int passes;

  booth_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .ACC_W    (ACC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .product     (product),
    .done        (done),
    .clear       (clear),
    .result_ready(result_ready),
    .acc_result  (acc_result),
    .result_valid(result_valid),
    .sat_flag    (sat_flag),
    .overrun     (overrun),
    .prod_count  (prod_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: running sum clamped after every addition
  function automatic int model_sum(input int vals[$], output bit sat);
    int acc;
    acc = 0;
    sat = 1'b0;
    foreach (vals[i]) begin
      acc = acc + vals[i];
      if (acc > SMAX) begin
        acc = SMAX;
        sat = 1'b1;
      end else if (acc < SMIN) begin
        acc = SMIN;
        sat = 1'b1;
      end
    end
    return acc;
  endfunction

  function automatic int sval(input logic [7:0] p);
    return int'($signed(p));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] p);
    product = p;
    done    = 1'b1;
    tick();
    done    = 1'b0;
    tick();
  endtask

  task automatic ack();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (acc_result !== '0 || result_valid !== 1'b0 ||
        sat_flag !== 1'b0 || overrun !== 1'b0 ||
        prod_count !== 4'd0) begin
      $display("FAIL %s: acc=%0d valid=%b sat=%b ovr=%b cnt=%0d want all 0",
               tag, acc_result, result_valid, sat_flag, overrun,
               prod_count);
    end else begin
      passes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    check_idle("reset_async");
    done    = 1'b1;
    product = 8'h11;
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (prod_count !== 4'd1 || $signed(acc_result) !== 17) begin
      $display("FAIL reset_done_high: cnt=%0d acc=%0d want 1/17",
               prod_count, acc_result);
    end else begin
      passes++;
    end
    done = 1'b0;
    do_clear();
    check_idle("reset_clear");
  endtask

  task automatic test_frame_basic();
    logic [7:0] ps [8];
    ps = '{8'h23, 8'hF4, 8'h04, 8'hFF, 8'h00, 8'h07, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      pulse(ps[i]);
      checks++;
      if (prod_count !== 4'(i + 1)) begin
        $display("FAIL basic_count%0d: got %0d want %0d",
                 i, prod_count, i + 1);
      end else begin
        passes++;
      end
    end
    checks++;
    if (result_valid !== 1'b1 || $signed(acc_result) !== 33 ||
        sat_flag !== 1'b0) begin
      $display("FAIL basic_result: valid=%b acc=%0d sat=%b want 1/33/0",
               result_valid, acc_result, sat_flag);
    end else begin
      passes++;
    end
    repeat (4) tick();
    checks++;
    if (result_valid !== 1'b1 || $signed(acc_result) !== 33 ||
        prod_count !== 4'd8) begin
      $display("FAIL basic_hold: valid=%b acc=%0d cnt=%0d want 1/33/8",
               result_valid, acc_result, prod_count);
    end else begin
      passes++;
    end
    ack();
    check_idle("basic_ack");
  endtask

  task automatic test_saturation();
    repeat (8) pulse(8'h40);
    checks++;
    if (result_valid !== 1'b1 || $signed(acc_result) !== SMAX ||
        sat_flag !== 1'b1) begin
      $display("FAIL sat_pos: valid=%b acc=%0d sat=%b want 1/%0d/1",
               result_valid, acc_result, sat_flag, SMAX);
    end else begin
      passes++;
    end
    ack();
    repeat (8) pulse(8'hC8);
    checks++;
    if (result_valid !== 1'b1 || $signed(acc_result) !== -448 ||
        sat_flag !== 1'b0) begin
      $display("FAIL sat_neg: valid=%b acc=%0d sat=%b want 1/-448/0",
               result_valid, acc_result, sat_flag);
    end else begin
      passes++;
    end
    ack();
    repeat (4) pulse(8'h80);
    repeat (4) pulse(8'h80);
    checks++;
    if ($signed(acc_result) !== SMIN || sat_flag !== 1'b1) begin
      $display("FAIL sat_min: acc=%0d sat=%b want %0d/1",
               acc_result, sat_flag, SMIN);
    end else begin
      passes++;
    end
    ack();
  endtask

  task automatic test_level_done();
    product = 8'h05;
    done    = 1'b1;
    repeat (20) tick();
    done = 1'b0;
    tick();
    checks++;
    if (prod_count !== 4'd1 || $signed(acc_result) !== 5 ||
        result_valid !== 1'b0) begin
      $display("FAIL level_done: cnt=%0d acc=%0d valid=%b want 1/5/0",
               prod_count, acc_result, result_valid);
    end else begin
      passes++;
    end
    do_clear();
    check_idle("level_clear");
  endtask

  task automatic test_hold_overrun();
    int  q[$];
    int  extra[$];
    int  exp;
    bit  sat;
    logic [7:0] p;
    q = {};
    for (int i = 0; i < 8; i++) begin
      p = 8'($urandom_range(0, 60));
      q.push_back(sval(p));
      pulse(p);
    end
    exp = model_sum(q, sat);
    extra = {};
    for (int i = 0; i < 3; i++) begin
      p = 8'($urandom_range(1, 50));
      extra.push_back(sval(p));
      pulse(p);
    end
    checks++;
    if (overrun !== 1'b1 || $signed(acc_result) !== exp ||
        prod_count !== 4'd8 || result_valid !== 1'b1) begin
      $display("FAIL hold_stable: ovr=%b acc=%0d cnt=%0d valid=%b want 1/%0d/8/1",
               overrun, acc_result, prod_count, result_valid, exp);
    end else begin
      passes++;
    end
    ack();
    tick();
    tick();
    exp = extra[0] + extra[1];
    checks++;
    if (prod_count !== 4'd2 || $signed(acc_result) !== exp ||
        overrun !== 1'b1) begin
      $display("FAIL hold_drain: cnt=%0d acc=%0d ovr=%b want 2/%0d/1",
               prod_count, acc_result, overrun, exp);
    end else begin
      passes++;
    end
    repeat (3) tick();
    checks++;
    if (prod_count !== 4'd2) begin
      $display("FAIL hold_third_dropped: cnt=%0d want 2", prod_count);
    end else begin
      passes++;
    end
    do_clear();
    check_idle("overrun_clear");
  endtask

  task automatic run_checked_frame(input string tag);
    int  q[$];
    int  exp;
    bit  sat;
    logic [7:0] p;
    q = {};
    for (int i = 0; i < FRAME_LEN; i++) begin
      p = 8'($urandom);
      q.push_back(sval(p));
      pulse(p);
      repeat ($urandom_range(0, 2)) tick();
    end
    exp = model_sum(q, sat);
    checks++;
    if (result_valid !== 1'b1 || $signed(acc_result) !== exp ||
        sat_flag !== sat || prod_count !== 4'(FRAME_LEN)) begin
      $display("FAIL %s: valid=%b acc=%0d sat=%b cnt=%0d want 1/%0d/%b/%0d",
               tag, result_valid, acc_result, sat_flag, prod_count,
               exp, sat, FRAME_LEN);
    end else begin
      passes++;
    end
    ack();
  endtask

  task automatic test_midframe_abort();
    repeat (5) pulse(8'($urandom_range(1, 100)));
    #2;
    reset = 1'b1;
    #1;
    check_idle("abort_reset");
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_checked_frame("abort_reset_frame");
    repeat (5) pulse(8'($urandom_range(1, 100)));
    do_clear();
    check_idle("abort_clear");
    run_checked_frame("abort_clear_frame");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      run_checked_frame($sformatf("random_frame%0d", f));
    end
  endtask

  task automatic test_back_to_back();
    int  q[$];
    int  exp;
    bit  sat;
    logic [7:0] p;
    repeat (FRAME_LEN) pulse(8'($urandom_range(0, 20)));
    q = {};
    for (int i = 0; i < 2; i++) begin
      p = 8'($urandom);
      q.push_back(sval(p));
      pulse(p);
    end
    ack();
    for (int i = 2; i < FRAME_LEN; i++) begin
      p = 8'($urandom);
      q.push_back(sval(p));
      pulse(p);
    end
    exp = model_sum(q, sat);
    checks++;
    if (result_valid !== 1'b1 || $signed(acc_result) !== exp ||
        sat_flag !== sat || overrun !== 1'b0) begin
      $display("FAIL b2b: valid=%b acc=%0d sat=%b ovr=%b want 1/%0d/%b/0",
               result_valid, acc_result, sat_flag, overrun, exp, sat);
    end else begin
      passes++;
    end
    ack();
  endtask

  initial begin
    checks       = 0;
    passes       = 0;
    reset        = 1'b1;
    done         = 1'b0;
    clear        = 1'b0;
    result_ready = 1'b0;
    product      = 8'h00;
    test_reset();
    test_frame_basic();
    test_saturation();
    test_level_done();
    test_hold_overrun();
    test_midframe_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
